// File: rtl/mmio_periph_pkg.sv
// mmio_periph_pkg: shared I/O address map, KCTRL bit positions and seven-segment decoder.
package mmio_periph_pkg;
  localparam int DBITS = 32;
  localparam logic [DBITS-1:0] ADDRHEX   = 32'hF0000000;
  localparam logic [DBITS-1:0] ADDRLEDR  = 32'hF0000004;
  localparam logic [DBITS-1:0] ADDRLEDG  = 32'hF0000008;
  localparam logic [DBITS-1:0] ADDRKEY   = 32'hF0000010;
  localparam logic [DBITS-1:0] ADDRSW    = 32'hF0000014;
  localparam logic [DBITS-1:0] ADDRKCTRL = 32'hF0000110;
  localparam int PEND_LSB = 0;
  localparam int OVR_BIT  = 8;
  // Active-low segments ordered gfedcba
  function automatic logic [6:0] seven_seg(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction
endpackage

// File: rtl/mmio_periph_if.sv
// mmio_periph_if: processor data-bus port seen by memory-mapped I/O.
interface mmio_periph_if import mmio_periph_pkg::*;;
  logic             wrmem;
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic [DBITS-1:0] rdata;
  logic             sel;
  modport master (output wrmem, addr, wdata, input rdata, sel);
  modport slave (input wrmem, addr, wdata, output rdata, sel);
endinterface

// File: rtl/mmio_periph_io_debounce.sv
// io_debounce: 2-flop synchronizer plus tick-sampled two-agreement debouncer.
module io_debounce #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise
);
  logic [WIDTH-1:0] sync1, sync2, sample, agree;
  assign agree = ~(sync2 ^ sample);
  // rise marks the edge on which stable is about to go 0->1
  assign rise = {WIDTH{tick}} & agree & sync2 & ~stable;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      sample <= '0;
      stable <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (tick) begin
        sample <= sync2;
        stable <= (agree & sync2) | (~agree & stable);
      end
    end
  end
endmodule

// File: rtl/mmio_periph.sv
// mmio_periph: HEX/LED output registers, debounced KEY/SW inputs and sticky key edge capture.
module mmio_periph import mmio_periph_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNTBITS         = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  mmio_periph_if.slave bus,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [9:0]  LEDR,
  output logic [7:0]  LEDG
);
  logic [CNTBITS-1:0] cnt;
  logic               tick;
  logic [15:0]        hex_out;
  logic [3:0]         key_stable, key_rise, pending, pend_n;
  logic [9:0]         sw_stable, sw_rise_unused;
  logic               ovr, ovr_n, clr;
  logic               hit_hex, hit_ledr, hit_ledg, hit_key, hit_sw, hit_kctrl;
  logic [DBITS-1:0]   kctrl_word;
  assign tick = cnt == CNTBITS'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  end
  io_debounce #(.WIDTH(4)) u_key (
    .clk(clk), .reset(reset), .tick(tick), .raw(~KEY),
    .stable(key_stable), .rise(key_rise)
  );
  io_debounce #(.WIDTH(10)) u_sw (
    .clk(clk), .reset(reset), .tick(tick), .raw(SW),
    .stable(sw_stable), .rise(sw_rise_unused)
  );
  assign hit_hex   = bus.addr == ADDRHEX;
  assign hit_ledr  = bus.addr == ADDRLEDR;
  assign hit_ledg  = bus.addr == ADDRLEDG;
  assign hit_key   = bus.addr == ADDRKEY;
  assign hit_sw    = bus.addr == ADDRSW;
  assign hit_kctrl = bus.addr == ADDRKCTRL;
  assign clr = bus.wrmem && hit_kctrl;
  // Write-1-to-clear, with a same-cycle key rise taking priority
  assign pend_n = (pending & ~(clr ? bus.wdata[PEND_LSB +: 4] : 4'b0)) | key_rise;
  assign ovr_n  = (ovr & ~(clr & bus.wdata[OVR_BIT])) | |(key_rise & pending);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_out <= 16'hDEAD;
      LEDR    <= '0;
      LEDG    <= '0;
      pending <= '0;
      ovr     <= 1'b0;
    end else begin
      if (bus.wrmem && hit_hex) hex_out <= bus.wdata[15:0];
      if (bus.wrmem && hit_ledr) LEDR <= bus.wdata[9:0];
      if (bus.wrmem && hit_ledg) LEDG <= bus.wdata[7:0];
      pending <= pend_n;
      ovr     <= ovr_n;
    end
  end
  always_comb begin
    kctrl_word                 = '0;
    kctrl_word[PEND_LSB +: 4]  = pending;
    kctrl_word[OVR_BIT]        = ovr;
  end
  assign bus.sel = hit_hex | hit_ledr | hit_ledg | hit_key | hit_sw | hit_kctrl;
  assign bus.rdata = hit_hex   ? {16'b0, hex_out}    :
                     hit_ledr  ? {22'b0, LEDR}       :
                     hit_ledg  ? {24'b0, LEDG}       :
                     hit_key   ? {28'b0, key_stable} :
                     hit_sw    ? {22'b0, sw_stable}  :
                     hit_kctrl ? kctrl_word          : 32'hDEADBEEF;
  assign HEX0 = seven_seg(hex_out[3:0]);
  assign HEX1 = seven_seg(hex_out[7:4]);
  assign HEX2 = seven_seg(hex_out[11:8]);
  assign HEX3 = seven_seg(hex_out[15:12]);
endmodule
